// File: rtl/lut_prober.sv
// Sweeps a 4-input LUT through all 16 vectors, samples its output and compares against EXPECT.
// Optional macro LUT_PROBE_FAILIDX_EN adds the lowest-mismatch index on fail_idx.
module lut_prober #(
  parameter logic [15:0] EXPECT = 16'b0,
  parameter int unsigned SETTLE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        d,
  output logic        c,
  output logic        b,
  output logic        a,
  input  logic        o,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [3:0]  fail_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Counter runs SETTLE-1 down to 0, giving SETTLE cycles in ST_SETTLE (SETTLE must be 2..15).
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic [1:0] o_sync;

  assign {d, c, b, a} = idx;

`ifdef LUT_PROBE_FAILIDX_EN
  logic [3:0] fail_q;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

  assign fail_idx = fail_q;
`else
  assign fail_idx = 4'd0;
`endif

  // done/busy/pass are registered in ST_DONE, so they appear together on the cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= 4'd0;
      cnt      <= 4'd0;
      o_sync   <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      captured <= 16'h0000;
`ifdef LUT_PROBE_FAILIDX_EN
      fail_q   <= 4'd0;
`endif
    end else begin
      o_sync <= {o_sync[0], o};
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETTLE;
            idx      <= 4'd0;
            cnt      <= CNT_LOAD;
            captured <= 16'h0000;
            pass     <= 1'b0;
            busy     <= 1'b1;
`ifdef LUT_PROBE_FAILIDX_EN
            fail_q   <= 4'd0;
`endif
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) state <= ST_SAMPLE;
          else cnt <= cnt - 4'd1;
        end
        ST_SAMPLE: begin
          captured[idx] <= o_sync[1];
          if (idx == 4'd15) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 4'd1;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (captured == EXPECT);
`ifdef LUT_PROBE_FAILIDX_EN
          fail_q <= lowest_set(captured ^ EXPECT);
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lut_prober.md
LUT_PROBER -- requirements
Module: lut_prober

Interface
REQ-001 Parameter EXPECT, default 16'b0, 16-bit truth table the probed LUT must implement; bit i is the required output for input vector i = {d,c,b,a}.
REQ-002 Parameter SETTLE, default 3, wait cycles per vector before sampling; legal range 2..15.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-006 Port d, c, b, a  output  1 each  vector driven into the probed LUT inputs; d is the MSB.
REQ-007 Port o  input  1  asynchronous output returned from the probed LUT.
REQ-008 Port busy  output  1  high from start acceptance until the done pulse.
REQ-009 Port done  output  1  single-cycle pulse when a sweep completes.
REQ-010 Port pass  output  1  high when captured equals EXPECT; valid from done until the next accepted start.
REQ-011 Port captured  output  16  sampled truth table; bit i holds o sampled for vector i.
REQ-012 Port fail_idx  output  4  index of the lowest mismatching vector (see Configuration).

Function
REQ-013 The block shall pass o through a 2-flop synchronizer before any use.
REQ-014 The FSM shall have the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE with start=1 at an edge shall enter SETTLE, set the vector index to 0, clear captured, clear pass and set busy.
REQ-016 {d,c,b,a} shall equal the vector index at all times; the index holds its value in IDLE and DONE.
REQ-017 SETTLE shall last exactly SETTLE cycles, counted by a 4-bit down-counter, then advance to SAMPLE.
REQ-018 SAMPLE shall last one cycle and write the synchronized o into captured[index].
REQ-019 After SAMPLE, an index below 15 shall increment and return to SETTLE; index 15 shall advance to DONE.
REQ-020 Each vector shall take SETTLE+1 cycles; done shall assert exactly 16*(SETTLE+1)+1 cycles after the start edge.
REQ-021 DONE shall last one cycle: done=1, busy falls, pass is updated from (captured==EXPECT) including the final sample, then the FSM returns to IDLE.
REQ-022 start while busy shall be ignored, with no restart and no queueing.
REQ-023 start held high continuously shall launch back-to-back sweeps, each beginning on the cycle after DONE.
REQ-024 The index shall not wrap past 15 within a sweep, and the index register shall never exceed 4 bits.
REQ-025 captured and pass shall hold their values in IDLE until the next accepted start.

Reset
REQ-026 rst_n low shall immediately force state=IDLE, index=0 ({d,c,b,a}=0), counter=0, synchronizer=0, busy=0, done=0, pass=0, captured=0 and fail_idx=0.
REQ-027 Reset asserted mid-sweep shall abort the sweep with no done pulse.
REQ-028 After rst_n deasserts, the first start shall be accepted on the first rising edge.

Configuration
REQ-029 The macro LUT_PROBE_FAILIDX_EN shall control fail_idx.
REQ-030 With LUT_PROBE_FAILIDX_EN defined, fail_idx shall latch the lowest index whose sample mismatched EXPECT, and shall be valid from done.
REQ-031 With LUT_PROBE_FAILIDX_EN defined and pass=1, fail_idx shall read 0.
REQ-032 With LUT_PROBE_FAILIDX_EN defined, fail_idx shall clear on start acceptance.
REQ-033 Without LUT_PROBE_FAILIDX_EN, fail_idx shall be tied to 0 and no comparison logic beyond pass shall exist.

Verification
REQ-034 Scenario, matching LUT: EXPECT=16'hCAFE, SETTLE=3, LUT model = 16'hCAFE, start pulse -> done at exactly cycle 65 after the start edge; captured=16'hCAFE; pass=1; fail_idx=0.
REQ-035 Scenario, single bit error: LUT model = 16'hCAFE^16'h0010 -> pass=0; captured=16'hCAEE; fail_idx=4 with the macro defined, 0 without it.
REQ-036 Scenario, sequencing check: LUT = `IA (16'hFF00) -> {d,c,b,a} steps 0..15, each value held 4 cycles; captured=16'hFF00.
REQ-037 Scenario, reset mid-sweep: rst_n low at vector 7 -> all outputs 0 immediately and no done pulse; a new start then completes normally.
REQ-038 Scenario, start while busy: start pulses at cycles 10 and 40 -> exactly one done pulse at cycle 65.
REQ-039 Scenario, continuous start, SETTLE=2: start held high -> done pulses spaced 50 cycles apart (49 sweep cycles plus the DONE cycle), busy low only during DONE.
